// File: rtl/tile_engine_pkg.sv
// Shared definitions for the tile engine and the pixel generator that draws its tiles.
// Holds the FSM encoding, playfield geometry defaults and the LFSR/lane helpers.
package tile_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam int DEF_LANES     = 6;
   localparam int DEF_SCREEN_H  = 480;
   localparam int DEF_TILE_H    = 80;
   localparam int DEF_HIT_Y     = 400;
   localparam int DEF_SPEED     = 2;
   localparam int DEF_SPAWN_GAP = 40;
   localparam int Y_W           = 10;
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Fibonacci form, taps 8,6,5,4: feedback enters at bit 0
   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [2:0] lane_of(input logic [7:0] l);
      return (l[2:0] < 3'd6) ? l[2:0] : l[2:0] - 3'd6;
   endfunction

endpackage

// File: rtl/tile_engine_if.sv
// Game-side bundle between the tile engine and its environment.
// Inputs are level/pulse signals sampled on clk; there is no valid/ready handshake.
interface tile_engine_if;
   import tile_engine_pkg::*;

   logic                       frame_tick;
   logic [DEF_LANES-1:0]       btn;
   logic                       start;
   logic [DEF_LANES-1:0]       tile_active;
   logic [DEF_LANES*Y_W-1:0]   tile_y;
   logic [7:0]                 score;
   logic                       game_over;
   logic                       playing;
   state_t                     state_dbg;

   modport master (
      output frame_tick, btn, start,
      input  tile_active, tile_y, score, game_over, playing, state_dbg
   );

   modport slave (
      input  frame_tick, btn, start,
      output tile_active, tile_y, score, game_over, playing, state_dbg
   );

endinterface

// File: rtl/tile_engine_lane.sv
// One lane: a single falling tile with its y register, hit window compare and
// advance/miss detection. Hits are judged on the pre-advance y and take priority.
module lane_tile #(
   parameter int SCREEN_H = tile_engine_pkg::DEF_SCREEN_H,
   parameter int TILE_H   = tile_engine_pkg::DEF_TILE_H,
   parameter int HIT_Y    = tile_engine_pkg::DEF_HIT_Y,
   parameter int SPEED    = tile_engine_pkg::DEF_SPEED
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         en,
   input  logic                         press,
   input  logic                         frame_tick,
   input  logic                         spawn,
   output logic                         active,
   output logic [tile_engine_pkg::Y_W-1:0] y,
   output logic                         hit,
   output logic                         wrong,
   output logic                         miss
);
   import tile_engine_pkg::*;

   localparam int EXT_W = Y_W + 1;

   logic [EXT_W-1:0] y_ext, bottom, adv;
   logic             hittable, over_edge;

   // One extra bit keeps y + TILE_H and y + SPEED from wrapping
   assign y_ext     = {1'b0, y};
   assign bottom    = y_ext + EXT_W'(TILE_H);
   assign adv       = y_ext + EXT_W'(SPEED);
   assign hittable  = active && (bottom >= EXT_W'(HIT_Y)) && (y_ext < EXT_W'(SCREEN_H));
   assign over_edge = (adv >= EXT_W'(SCREEN_H));

   assign hit   = en & press & hittable;
   assign wrong = en & press & ~hittable;
   assign miss  = en & frame_tick & active & ~hit & over_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= 1'b0;
         y      <= '0;
      end else if (clear) begin
         active <= 1'b0;
         y      <= '0;
      end else if (en) begin
         if (hit) begin
            active <= 1'b0;
         end else if (active) begin
            if (frame_tick && !over_edge) y <= adv[Y_W-1:0];
         end else if (spawn) begin
            active <= 1'b1;
            y      <= '0;
         end
      end
   end

endmodule

// File: rtl/tile_engine.sv
// Falling-tile rhythm game core: game FSM, press edge detection, spawn timer,
// LFSR lane picker and saturating score around six lane_tile instances.
module tile_engine #(
   parameter int LANES     = tile_engine_pkg::DEF_LANES,
   parameter int SCREEN_H  = tile_engine_pkg::DEF_SCREEN_H,
   parameter int TILE_H    = tile_engine_pkg::DEF_TILE_H,
   parameter int HIT_Y     = tile_engine_pkg::DEF_HIT_Y,
   parameter int SPEED     = tile_engine_pkg::DEF_SPEED,
   parameter int SPAWN_GAP = tile_engine_pkg::DEF_SPAWN_GAP
) (
   input  logic         clk,
   input  logic         rst_n,
   tile_engine_if.slave bus
);
   import tile_engine_pkg::*;

   localparam int CNT_W = $clog2(SPAWN_GAP);

   state_t                 state, state_nxt;
   logic                   clear, en, spawn_now;
   logic [LANES-1:0]       btn_q, press, active, hit, wrong, miss, spawn_vec;
   logic [LANES*Y_W-1:0]   y_flat;
   logic [7:0]             lfsr, score, score_nxt;
   logic [CNT_W-1:0]       spawn_cnt, spawn_cnt_nxt;
   logic [3:0]             hit_cnt;
   logic [8:0]             score_sum;

   assign en    = (state == ST_PLAY);
   assign press = bus.btn & ~btn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      case (state)
         ST_IDLE, ST_OVER: begin
            if (bus.start) begin
               state_nxt = ST_PLAY;
               clear     = 1'b1;
            end
         end
         ST_PLAY: begin
            if ((|wrong) || (|miss)) state_nxt = ST_OVER;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      spawn_cnt_nxt = spawn_cnt;
      spawn_now     = 1'b0;
      hit_cnt       = '0;
      if (en && bus.frame_tick) begin
         if (spawn_cnt == CNT_W'(SPAWN_GAP - 1)) begin
            spawn_cnt_nxt = '0;
            spawn_now     = 1'b1;
         end else begin
            spawn_cnt_nxt = spawn_cnt + 1'b1;
         end
      end
      for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + {3'b000, hit[i]};
      score_sum = {1'b0, score} + {5'b00000, hit_cnt};
      if (clear) begin
         spawn_cnt_nxt = '0;
         score_nxt     = '0;
      end else if (score_sum > 9'd255) begin
         score_nxt = 8'hFF;
      end else begin
         score_nxt = score_sum[7:0];
      end
   end

   // A lane that is occupied at cycle start (even if hit now) rejects the spawn
   assign spawn_vec = spawn_now ? (LANES'(1) << lane_of(lfsr)) : {LANES{1'b0}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr      <= LFSR_SEED;
         btn_q     <= '0;
         spawn_cnt <= '0;
         score     <= '0;
      end else begin
         lfsr      <= lfsr_step(lfsr);
         btn_q     <= bus.btn;
         spawn_cnt <= spawn_cnt_nxt;
         score     <= score_nxt;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_tile #(
         .SCREEN_H (SCREEN_H),
         .TILE_H   (TILE_H),
         .HIT_Y    (HIT_Y),
         .SPEED    (SPEED)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .clear      (clear),
         .en         (en),
         .press      (press[g]),
         .frame_tick (bus.frame_tick),
         .spawn      (spawn_vec[g]),
         .active     (active[g]),
         .y          (y_flat[g*Y_W +: Y_W]),
         .hit        (hit[g]),
         .wrong      (wrong[g]),
         .miss       (miss[g])
      );
   end

   assign bus.tile_active = active;
   assign bus.tile_y      = y_flat;
   assign bus.score       = score;
   assign bus.game_over   = (state == ST_OVER);
   assign bus.playing     = (state == ST_PLAY);
   assign bus.state_dbg   = state;

endmodule

// File: tb/tb_tile_engine.sv
// Bench for tile_engine: directed game scenarios plus a randomized auto-player,
// all checked against a tile-list game model kept in this file.
module tb_tile_engine;
   import tile_engine_pkg::*;

   localparam int SCREEN_H  = 480;
   localparam int TILE_H    = 80;
   localparam int HIT_Y     = 400;
   localparam int SPEED     = 2;
   localparam int SPAWN_GAP = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   tile_engine_if bus();

   tile_engine #(
      .LANES(6), .SCREEN_H(SCREEN_H), .TILE_H(TILE_H), .HIT_Y(HIT_Y),
      .SPEED(SPEED), .SPAWN_GAP(SPAWN_GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- game model ----------------
   int         m_state;      // 0 idle, 1 play, 2 over
   bit         m_active[6];
   int         m_y[6];
   int         m_score;
   int         m_ticks;      // frame ticks since game start, modulo the spawn gap
   int         m_hit_total;
   logic [5:0] m_btn;
   logic [7:0] m_lfsr;

   function automatic logic [7:0] ref_lfsr(input logic [7:0] l);
      return {l[6:0], ^(l & 8'hB8)};
   endfunction

   function automatic int ref_lane(input logic [7:0] l);
      int v;
      v = int'(l) % 8;
      return (v >= 6) ? v - 6 : v;
   endfunction

   function automatic logic [7:0] lfsr_ahead(input logic [7:0] l, input int n);
      logic [7:0] v;
      v = l;
      for (int i = 0; i < n; i++) v = ref_lfsr(v);
      return v;
   endfunction

   function automatic bit can_hit(input int i);
      return m_active[i] && (m_y[i] + TILE_H >= HIT_Y) && (m_y[i] < SCREEN_H);
   endfunction

   function automatic logic [5:0] exp_active();
      logic [5:0] v;
      for (int i = 0; i < 6; i++) v[i] = m_active[i];
      return v;
   endfunction

   function automatic logic [59:0] exp_y();
      logic [59:0] v;
      for (int i = 0; i < 6; i++) v[i*10 +: 10] = 10'(m_y[i]);
      return v;
   endfunction

   function automatic int n_active();
      int n = 0;
      for (int i = 0; i < 6; i++) n += int'(m_active[i]);
      return n;
   endfunction

   task automatic model_reset();
      m_state = 0; m_score = 0; m_ticks = 0; m_btn = '0; m_lfsr = 8'hA5;
      for (int i = 0; i < 6; i++) begin m_active[i] = 1'b0; m_y[i] = 0; end
   endtask

   task automatic model_step(input logic ft, input logic [5:0] b, input logic st);
      logic [5:0] pr;
      bit         was[6];
      bit         bad, spawn;
      int         hits, ln;
      pr = b & ~m_btn;
      m_btn = b;
      ln = ref_lane(m_lfsr);
      m_lfsr = ref_lfsr(m_lfsr);
      if (m_state != 1) begin
         if (st) begin
            m_state = 1; m_score = 0; m_ticks = 0;
            for (int i = 0; i < 6; i++) begin m_active[i] = 1'b0; m_y[i] = 0; end
         end
      end else begin
         bad = 1'b0; spawn = 1'b0; hits = 0;
         if (ft) begin
            m_ticks++;
            if (m_ticks == SPAWN_GAP) begin m_ticks = 0; spawn = 1'b1; end
         end
         was = m_active;
         for (int i = 0; i < 6; i++) begin
            if (pr[i]) begin
               if (can_hit(i)) begin m_active[i] = 1'b0; hits++; end
               else bad = 1'b1;
            end
            if (ft && m_active[i]) begin
               if (m_y[i] + SPEED >= SCREEN_H) bad = 1'b1;
               else m_y[i] += SPEED;
            end
         end
         if (spawn && !was[ln]) begin m_active[ln] = 1'b1; m_y[ln] = 0; end
         m_hit_total += hits;
         m_score = (m_score + hits > 255) ? 255 : m_score + hits;
         if (bad) m_state = 2;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns 1 time unit after the next one.
   task automatic drive(input logic ft, input logic [5:0] b, input logic st);
      bus.frame_tick = ft; bus.btn = b; bus.start = st;
      @(posedge clk);
      model_step(ft, b, st);
      #1;
   endtask

   task automatic end_game();
      int w;
      if (m_state == 1) begin
         drive(1'b0, 6'd0, 1'b0);
         w = 0;
         for (int i = 5; i >= 0; i--) if (!can_hit(i)) w = i;
         drive(1'b0, 6'(1 << w), 1'b0);
         drive(1'b0, 6'd0, 1'b0);
      end
   endtask

   task automatic start_for_lane(input int want);
      int n = 0;
      end_game();
      while (ref_lane(lfsr_ahead(m_lfsr, SPAWN_GAP)) != want && n < 300) begin
         drive(1'b0, 6'd0, 1'b0);
         n++;
      end
      drive(1'b0, 6'd0, 1'b1);
      repeat (SPAWN_GAP) drive(1'b1, 6'd0, 1'b0);
      checks++;
      if (bus.tile_active !== exp_active() || bus.tile_active[want] !== 1'b1) begin
         errors++;
         $display("FAIL spawn_lane%0d: tile_active=%b expected %b", want, bus.tile_active, exp_active());
      end
   endtask

   task automatic advance_to(input int lane, input int y);
      int n = 0;
      while (m_y[lane] < y && n < 400) begin
         drive(1'b1, 6'd0, 1'b0);
         n++;
      end
      checks++;
      if (bus.tile_y[lane*10 +: 10] !== 10'(y) || m_state != 1) begin
         errors++;
         $display("FAIL advance_lane%0d: tile_y=%0d expected %0d", lane, bus.tile_y[lane*10 +: 10], y);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if (bus.tile_active !== 6'd0) begin errors++; $display("FAIL reset_active: got %b expected 0", bus.tile_active); end
      checks++;
      if (bus.tile_y !== 60'd0) begin errors++; $display("FAIL reset_y: got %h expected 0", bus.tile_y); end
      checks++;
      if (bus.score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", bus.score); end
      checks++;
      if (bus.game_over !== 1'b0 || bus.playing !== 1'b0 || bus.state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: over=%b playing=%b expected 0 0", bus.game_over, bus.playing);
      end
   endtask

   task automatic test_idle();
      for (int k = 0; k < 20; k++) begin
         drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b0);
         checks++;
         if ({bus.tile_active, bus.tile_y, bus.score, bus.game_over, bus.playing} !== 76'd0) begin
            errors++;
            $display("FAIL idle_hold: active=%b score=%0d playing=%b expected all zero", bus.tile_active, bus.score, bus.playing);
         end
      end
      drive(1'b0, 6'd0, 1'b0);
   endtask

   task automatic test_first_spawn();
      int ln;
      drive(1'b0, 6'd0, 1'b1);
      checks++;
      if (bus.playing !== 1'b1 || bus.tile_active !== 6'd0 || bus.score !== 8'd0) begin
         errors++;
         $display("FAIL start_play: playing=%b active=%b score=%0d expected 1 0 0", bus.playing, bus.tile_active, bus.score);
      end
      repeat (SPAWN_GAP - 1) drive(1'b1, 6'd0, 1'b0);
      checks++;
      if (bus.tile_active !== 6'd0) begin errors++; $display("FAIL pre_spawn: active=%b expected 0", bus.tile_active); end
      ln = ref_lane(m_lfsr);
      drive(1'b1, 6'd0, 1'b0);
      checks++;
      if (bus.tile_active !== 6'(1 << ln) || bus.tile_y !== 60'd0) begin
         errors++;
         $display("FAIL first_spawn: active=%b y=%h expected %b y=0", bus.tile_active, bus.tile_y, 6'(1 << ln));
      end
   endtask

   task automatic test_hit_lane2();
      start_for_lane(2);
      advance_to(2, 330);
      drive(1'b0, 6'b000100, 1'b0);
      checks++;
      if (bus.tile_active[2] !== 1'b0 || bus.score !== 8'd1 || bus.playing !== 1'b1) begin
         errors++;
         $display("FAIL hit_lane2: active2=%b score=%0d playing=%b expected 0 1 1", bus.tile_active[2], bus.score, bus.playing);
      end
      checks++;
      if (bus.tile_active !== exp_active() || bus.tile_y !== exp_y()) begin
         errors++;
         $display("FAIL hit_lane2_tiles: active=%b expected %b", bus.tile_active, exp_active());
      end
   endtask

   task automatic test_wrong_press();
      logic [59:0] y_frozen;
      start_for_lane(0);
      advance_to(0, 100);
      drive(1'b0, 6'b000001, 1'b0);
      checks++;
      if (bus.game_over !== 1'b1 || bus.playing !== 1'b0 || bus.score !== 8'd0 || bus.tile_active[0] !== 1'b1) begin
         errors++;
         $display("FAIL wrong_press: over=%b score=%0d active0=%b expected 1 0 1", bus.game_over, bus.score, bus.tile_active[0]);
      end
      y_frozen = exp_y();
      for (int k = 0; k < 8; k++) drive(1'b1, 6'($urandom_range(0, 63)), 1'b0);
      checks++;
      if (bus.tile_y !== y_frozen || bus.tile_active !== exp_active() || bus.game_over !== 1'b1) begin
         errors++;
         $display("FAIL over_frozen: y=%h expected %h", bus.tile_y, y_frozen);
      end
   endtask

   task automatic test_miss_edge();
      start_for_lane(3);
      advance_to(3, 478);
      drive(1'b1, 6'd0, 1'b0);
      checks++;
      if (bus.game_over !== 1'b1 || bus.tile_y[39:30] !== 10'd478 || bus.tile_active[3] !== 1'b1) begin
         errors++;
         $display("FAIL miss_edge: over=%b y3=%0d expected 1 478", bus.game_over, bus.tile_y[39:30]);
      end
   endtask

   task automatic test_hit_on_edge();
      start_for_lane(3);
      advance_to(3, 478);
      drive(1'b1, 6'b001000, 1'b0);
      checks++;
      if (bus.game_over !== 1'b0 || bus.playing !== 1'b1 || bus.score !== 8'd1 || bus.tile_active[3] !== 1'b0) begin
         errors++;
         $display("FAIL hit_on_edge: over=%b score=%0d active3=%b expected 0 1 0", bus.game_over, bus.score, bus.tile_active[3]);
      end
      checks++;
      if (bus.tile_y !== exp_y() || bus.tile_active !== exp_active()) begin
         errors++;
         $display("FAIL hit_on_edge_tiles: y=%h expected %h", bus.tile_y, exp_y());
      end
   endtask

   task automatic test_multi_press();
      int h = -1, w = -1, n = 0, prev;
      drive(1'b0, 6'd0, 1'b0);
      while (h < 0 && n < 300) begin
         for (int i = 0; i < 6; i++) if (can_hit(i)) h = i;
         if (h < 0) drive(1'b1, 6'd0, 1'b0);
         n++;
      end
      for (int i = 0; i < 6; i++) if (!can_hit(i)) w = i;
      prev = m_score;
      if (h >= 0 && w >= 0) drive(1'b0, 6'((1 << h) | (1 << w)), 1'b0);
      checks++;
      if (h < 0 || w < 0 || bus.game_over !== 1'b1 || bus.score !== 8'(prev + 1) || bus.tile_active[h] !== 1'b0) begin
         errors++;
         $display("FAIL multi_press: over=%b score=%0d expected 1 %0d (lanes %0d/%0d)", bus.game_over, bus.score, prev + 1, h, w);
      end
   endtask

   task automatic test_saturate();
      int         cyc = 0, target;
      logic [5:0] mask;
      end_game();
      drive(1'b0, 6'd0, 1'b1);
      target = m_hit_total + 258;
      while (cyc < 60000 && m_hit_total < target && m_state == 1) begin
         cyc++;
         if (m_btn != 6'd0) begin
            drive(1'b0, 6'd0, 1'($urandom_range(0, 1)));
         end else begin
            mask = '0;
            for (int i = 0; i < 6; i++)
               if (can_hit(i) && (m_y[i] >= 470 || $urandom_range(0, 3) == 0)) mask[i] = 1'b1;
            drive(1'($urandom_range(0, 7) != 0), mask, 1'($urandom_range(0, 1)));
         end
         checks++;
         if ({bus.tile_active, bus.tile_y, bus.score, bus.game_over, bus.playing} !==
             {exp_active(), exp_y(), 8'(m_score), 1'(m_state == 2), 1'(m_state == 1)}) begin
            errors++;
            $display("FAIL autoplay cycle %0d: active=%b score=%0d over=%b expected %b %0d %b",
                     cyc, bus.tile_active, bus.score, bus.game_over, exp_active(), m_score, m_state == 2);
            break;
         end
      end
      checks++;
      if (bus.score !== 8'd255 || bus.playing !== 1'b1 || m_hit_total < target) begin
         errors++;
         $display("FAIL score_saturate: score=%0d playing=%b expected 255 1", bus.score, bus.playing);
      end
   endtask

   task automatic test_reset_mid_game();
      int cyc = 0;
      logic [5:0] mask;
      end_game();
      drive(1'b0, 6'd0, 1'b1);
      while (cyc < 8000 && !(m_score >= 7 && n_active() >= 3) && m_state == 1) begin
         cyc++;
         mask = '0;
         if (m_btn == 6'd0)
            for (int i = 0; i < 6; i++) if (can_hit(i) && m_y[i] >= 470) mask[i] = 1'b1;
         drive(1'(m_btn == 6'd0), mask, 1'b0);
      end
      checks++;
      if (bus.score !== 8'(m_score) || bus.tile_active !== exp_active() || m_score < 7 || n_active() < 3) begin
         errors++;
         $display("FAIL pre_reset_game: score=%0d active=%b expected %0d %b", bus.score, bus.tile_active, m_score, exp_active());
      end
      #2 rst_n = 1'b0;
      bus.frame_tick = 1'b0; bus.btn = '0; bus.start = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({bus.tile_active, bus.tile_y, bus.score, bus.game_over, bus.playing} !== 76'd0 || bus.state_dbg !== ST_IDLE) begin
         errors++;
         $display("FAIL async_reset: active=%b score=%0d playing=%b expected all zero", bus.tile_active, bus.score, bus.playing);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b0, 6'd0, 1'b1);
      checks++;
      if (bus.playing !== 1'b1 || bus.tile_active !== 6'd0 || bus.score !== 8'd0) begin
         errors++;
         $display("FAIL restart_after_reset: playing=%b active=%b score=%0d expected 1 0 0", bus.playing, bus.tile_active, bus.score);
      end
   endtask

   // ---------------- clock/reset and sequence ----------------
   initial begin
      bus.frame_tick = 1'b0; bus.btn = '0; bus.start = 1'b0;
      m_hit_total = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_idle();
      test_first_spawn();
      test_hit_lane2();
      test_wrong_press();
      test_miss_edge();
      test_hit_on_edge();
      test_multi_press();
      test_saturate();
      test_reset_mid_game();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tile_engine.md
TILE_ENGINE -- requirements
Module: tile_engine

Interface
REQ-001 Parameter LANES, default 6, number of key lanes (fixed at 6 for this revision).
REQ-002 Parameter SCREEN_H, default 480, visible lines; a tile whose top y reaches this value has left the screen.
REQ-003 Parameter TILE_H, default 80, tile height in lines.
REQ-004 Parameter HIT_Y, default 400, hit-line row; a tile is hittable when y + TILE_H >= HIT_Y and y < SCREEN_H.
REQ-005 Parameter SPEED, default 2, lines advanced per frame_tick.
REQ-006 Parameter SPAWN_GAP, default 40, frame_ticks between spawn attempts.
REQ-007 clk  in  1  system clock, same domain as the VGA pixel-tick logic.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 frame_tick  in  1  one-cycle pulse, once per frame at vertical-blank start.
REQ-010 btn  in  6  debounced key levels, bit i = lane i.
REQ-011 start  in  1  one-cycle start request.
REQ-012 tile_active  out  6  bit i high = lane i holds a tile.
REQ-013 tile_y  out  60  packed tile top rows, lane i at bits [10i+9:10i].
REQ-014 score  out  8  hits this game, saturating.
REQ-015 game_over  out  1  high in OVER state.
REQ-016 playing  out  1  high in PLAY state.

Function
REQ-017 FSM states IDLE, PLAY, OVER; outputs change only on clk rising edge.
REQ-018 IDLE/OVER + start -> PLAY next cycle; tile_active, all tile_y, score, spawn counter cleared in the same edge.
REQ-019 start ignored in PLAY.
REQ-020 Each lane holds at most one tile; tile_y is 10-bit unsigned.
REQ-021 Button press = btn rising edge, detected internally with a 6-bit registered copy of btn (registered copy updates in all states).
REQ-022 PLAY, press in lane i with a hittable tile -> tile_active[i] cleared, score+1 (saturate at 255), next cycle.
REQ-023 PLAY, press in lane i with no tile or non-hittable tile -> OVER next cycle; score held.
REQ-024 Presses in several lanes in one cycle are evaluated independently; any wrong press -> OVER, and correct hits in that same cycle still score.
REQ-025 PLAY + frame_tick: each active tile y += SPEED.
REQ-026 Active tile whose pre-advance y + SPEED >= SCREEN_H -> miss -> OVER; tile_y of that lane is not advanced (no 10-bit wrap).
REQ-027 Same cycle press-hit and frame_tick on one lane: hit evaluated on pre-advance y; hit wins, no miss.
REQ-028 Spawn counter increments per frame_tick in PLAY; on reaching SPAWN_GAP-1 it wraps to 0 and a spawn attempt occurs in that cycle.
REQ-029 Spawn lane = lfsr[2:0] if < 6, else lfsr[2:0] - 6.
REQ-030 Spawn into a lane already active (at cycle start) is dropped, with no retry; a spawned tile gets y = 0 and is not advanced that cycle.
REQ-031 Lane cleared by a hit in the same cycle as a spawn into it: spawn dropped.
REQ-032 LFSR 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5, advances every clk in all states, never all-zero.
REQ-033 OVER: tiles, tile_y, score frozen; frame_tick and btn ignored except via REQ-021 edge register.
REQ-034 IDLE: all outputs hold reset values.

Reset
REQ-035 rst_n low -> state IDLE, tile_active 0, tile_y all 0, score 0, game_over 0, playing 0, spawn counter 0, btn register 0, LFSR 8'hA5, immediately and independent of clk.
REQ-036 Reset mid-game discards all tiles and score; no spurious press after release (btn register cleared, so held key yields an edge only if high at first post-reset sample — this is by design and ignored in IDLE).

Structure
REQ-037 Shared package holds FSM state enum, LANES, SCREEN_H, TILE_H, HIT_Y defaults, consumed also by pixel_gen for drawing.
REQ-038 One sub-module lane_tile (single-lane y register, active flag, hittable compare, advance/miss), instantiated 6 times; FSM, LFSR, spawn and score in tile_engine.

Verification
REQ-039 Reset, start, 40 frame_ticks, LFSR seed A5 -> exactly one tile_active bit set at lane derived from LFSR, y = 0.
REQ-040 Tile in lane 2 advanced to y = 330 (330+80 >= 400), rise btn[2] -> tile_active[2] = 0, score = 1, playing = 1.
REQ-041 Tile in lane 0 at y = 100, rise btn[0] -> game_over = 1 next cycle, score unchanged.
REQ-042 Tile at y = 478, frame_tick with no press -> game_over = 1, tile_y = 478 held; same setup with btn rise in same cycle -> hit, score+1, no OVER.
REQ-043 Score at 255, valid hit -> score stays 255.
REQ-044 rst_n low mid-PLAY with 3 tiles, score 7 -> all outputs zero/IDLE without a clk edge; start -> PLAY with empty lanes.
